// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: two write ports, NREAD packed
// read ports, the clear-engine handshake and the write-conflict flag.
interface reg_file_mp_if #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 4,
  parameter int NREAD   = 2
);
  logic                     we_a;
  logic [REGBITS-1:0]       waddr_a;
  logic [WIDTH-1:0]         wdata_a;
  logic                     we_b;
  logic [REGBITS-1:0]       waddr_b;
  logic [WIDTH-1:0]         wdata_b;
  logic [NREAD*REGBITS-1:0] raddr;
  logic [NREAD*WIDTH-1:0]   rdata;
  logic                     clear_req;
  logic                     busy;
  logic                     wr_conflict;

  modport master (
    output we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, raddr, clear_req,
    input  rdata, busy, wr_conflict
  );

  modport slave (
    input  we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, raddr, clear_req,
    output rdata, busy, wr_conflict
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: NREAD combinational reads, two prioritised write
// ports (B over A), optional bypass / hardwired zero, background clear engine.
module reg_file_mp #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 4,
  parameter int NREAD   = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_mp_if.slave  bus
);
  localparam int DEPTH = 2 ** REGBITS;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [REGBITS-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               wr_conflict_q, wr_conflict_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];

  logic               idle;
  logic               wen_a;
  logic               wen_b;

  function automatic logic is_zero_reg(input logic [REGBITS-1:0] addr);
    return (ZERO_R0 != 0) && (addr == '0);
  endfunction

  // Effective write enables: writes only land in IDLE and never on a hardwired zero entry.
  always_comb begin
    idle  = (state_q == IDLE);
    wen_a = idle && bus.we_a && !is_zero_reg(bus.waddr_a);
    wen_b = idle && bus.we_b && !is_zero_reg(bus.waddr_b);
  end

  always_comb begin
    mem_d         = mem_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_conflict_d = wen_a && wen_b && (bus.waddr_a == bus.waddr_b);
    case (state_q)
      IDLE: begin
        // B is applied last so it wins an address collision with A.
        if (wen_a) mem_d[bus.waddr_a] = bus.wdata_a;
        if (wen_b) mem_d[bus.waddr_b] = bus.wdata_b;
        cnt_d = '0;
        if (bus.clear_req) state_d = CLEAR;
      end
      CLEAR: begin
        mem_d[cnt_q] = '0;
        cnt_d        = cnt_q + REGBITS'(1);
        if (cnt_q == REGBITS'(DEPTH - 1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q         <= '{default: '0};
      state_q       <= IDLE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [REGBITS-1:0] ra;
    logic [WIDTH-1:0]   rd;

    assign ra = bus.raddr[i*REGBITS +: REGBITS];

    // Forwarding follows write priority; the zero register masks everything, bypass included.
    always_comb begin
      rd = mem_q[ra];
      if ((BYPASS != 0) && wen_a && (bus.waddr_a == ra)) rd = bus.wdata_a;
      if ((BYPASS != 0) && wen_b && (bus.waddr_b == ra)) rd = bus.wdata_b;
      if (is_zero_reg(ra)) rd = '0;
    end

    assign bus.rdata[i*WIDTH +: WIDTH] = rd;
  end

  assign bus.busy        = busy_q;
  assign bus.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: three instances (bypass, no bypass, zero-r0) share one stimulus.
module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic        we_a, we_b, clear_req;
  logic [3:0]  waddr_a, waddr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [7:0]  raddr;

  int n_cmp  = 0;
  int n_fail = 0;
  int n;

  always #5 clk = ~clk;

  // ifs[0]: BYPASS=1; ifs[1]: BYPASS=0; ifs[2]: BYPASS=1, ZERO_R0=1
  reg_file_mp_if #(.WIDTH(32), .REGBITS(4), .NREAD(2)) ifs [3] ();

  for (genvar k = 0; k < 3; k++) begin : g_dut
    assign ifs[k].we_a      = we_a;
    assign ifs[k].waddr_a   = waddr_a;
    assign ifs[k].wdata_a   = wdata_a;
    assign ifs[k].we_b      = we_b;
    assign ifs[k].waddr_b   = waddr_b;
    assign ifs[k].wdata_b   = wdata_b;
    assign ifs[k].raddr     = raddr;
    assign ifs[k].clear_req = clear_req;

    reg_file_mp #(
      .WIDTH(32), .REGBITS(4), .NREAD(2),
      .BYPASS((k == 1) ? 0 : 1), .ZERO_R0((k == 2) ? 1 : 0)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifs[k])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      we_a = 1'b1; waddr_a = 4'(i); wdata_a = base + 32'(i);
      tick();
    end
    we_a = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we_a = 1'b0; we_b = 1'b0; clear_req = 1'b0;
    waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0; raddr = '0;
    tick(); tick();
    reset = 1'b0;

    // 1: reset state
    for (int i = 0; i < 16; i++) begin
      raddr = {4'(i), 4'(i)};
      #1;
      check("reset_rd0", ifs[0].rdata[31:0], 32'h0);
      check("reset_rd1", ifs[0].rdata[63:32], 32'h0);
    end
    check("reset_busy", {31'h0, ifs[0].busy}, 32'h0);
    check("reset_conf", {31'h0, ifs[0].wr_conflict}, 32'h0);

    // 2: bypass vs stored read
    we_a = 1'b1; waddr_a = 4'd3; wdata_a = 32'hDEADBEEF; raddr = {4'd0, 4'd3};
    #1;
    check("byp_same", ifs[0].rdata[31:0], 32'hDEADBEEF);
    check("nobyp_same", ifs[1].rdata[31:0], 32'h0);
    tick();
    we_a = 1'b0;
    #1;
    check("nobyp_next", ifs[1].rdata[31:0], 32'hDEADBEEF);
    check("byp_next", ifs[0].rdata[31:0], 32'hDEADBEEF);

    // 3: A/B collision on address 5
    we_a = 1'b1; waddr_a = 4'd5; wdata_a = 32'h11;
    we_b = 1'b1; waddr_b = 4'd5; wdata_b = 32'h22; raddr = {4'd5, 4'd5};
    #1;
    check("byp_b_wins", ifs[0].rdata[31:0], 32'h22);
    tick();
    we_a = 1'b0; we_b = 1'b0;
    #1;
    check("conf_mem5", ifs[1].rdata[31:0], 32'h22);
    check("conf_mem5_p1", ifs[0].rdata[63:32], 32'h22);
    check("conf_set", {31'h0, ifs[0].wr_conflict}, 32'h1);
    tick();
    check("conf_clr", {31'h0, ifs[0].wr_conflict}, 32'h0);
    we_a = 1'b1; waddr_a = 4'd1; wdata_a = 32'hA1;
    we_b = 1'b1; waddr_b = 4'd2; wdata_b = 32'hB2;
    tick();
    we_a = 1'b0; we_b = 1'b0; raddr = {4'd2, 4'd1};
    #1;
    check("diff_conf", {31'h0, ifs[0].wr_conflict}, 32'h0);
    check("diff_a", ifs[1].rdata[31:0], 32'hA1);
    check("diff_b", ifs[1].rdata[63:32], 32'hB2);

    // 4: background clear
    fill(32'h0);
    raddr = {4'd15, 4'd9};
    #1;
    check("fill_9", ifs[0].rdata[31:0], 32'd9);
    check("fill_15", ifs[0].rdata[63:32], 32'd15);
    raddr = {4'd0, 4'd7};
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (ifs[0].busy && n < 40) begin
      if (n == 5) begin
        we_a = 1'b1; waddr_a = 4'd7; wdata_a = 32'h77;
        #1;
        check("clr_no_byp", ifs[0].rdata[31:0], 32'd7);
      end else begin
        we_a = 1'b0;
      end
      clear_req = (n == 8);
      tick();
      n++;
    end
    we_a = 1'b0; clear_req = 1'b0;
    check("busy_len", 32'(n), 32'd16);
    tick();
    check("busy_stays_low", {31'h0, ifs[0].busy}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      raddr = {4'(i), 4'(i)};
      #1;
      check("after_clr", ifs[0].rdata[31:0], 32'h0);
    end

    // 5: reset aborts a clear
    fill(32'h100);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (5) tick();
    check("busy_mid", {31'h0, ifs[0].busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_busy", {31'h0, ifs[0].busy}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      raddr = {4'(i), 4'(i)};
      #1;
      check("rst_clr", ifs[1].rdata[63:32], 32'h0);
    end
    we_a = 1'b1; waddr_a = 4'd4; wdata_a = 32'h4444; raddr = {4'd0, 4'd4};
    tick();
    we_a = 1'b0;
    #1;
    check("post_rst_wr", ifs[1].rdata[31:0], 32'h4444);

    // 6: hardwired zero register
    we_a = 1'b1; waddr_a = 4'd0; wdata_a = 32'hFF; raddr = {4'd0, 4'd0};
    #1;
    check("z_same", ifs[2].rdata[31:0], 32'h0);
    check("nz_same", ifs[0].rdata[31:0], 32'hFF);
    tick();
    we_a = 1'b0;
    #1;
    check("z_next", ifs[2].rdata[31:0], 32'h0);
    check("z_conf", {31'h0, ifs[2].wr_conflict}, 32'h0);
    we_a = 1'b1; waddr_a = 4'd0; wdata_a = 32'h5;
    we_b = 1'b1; waddr_b = 4'd0; wdata_b = 32'h6;
    tick();
    we_a = 1'b0; we_b = 1'b0;
    #1;
    check("z_conf_ab", {31'h0, ifs[2].wr_conflict}, 32'h0);
    check("nz_conf_ab", {31'h0, ifs[0].wr_conflict}, 32'h1);
    check("z_rd_ab", ifs[2].rdata[63:32], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
